video_stream_out: RTL and testbench
===================================

VIDEO_STREAM_OUT -- requirements
Module: video_stream_out

Interface
REQ-001 BPS, default 8, bits per colour channel.
REQ-002 CHANNELS, default 3, colour channels per pixel; pixel width PW = BPS*CHANNELS.
REQ-003 H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 1024/24/136/160, horizontal timing in clocks; H_TOTAL = sum of all four.
REQ-004 V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 768/3/6/29, vertical timing in lines; V_TOTAL = sum of all four.
REQ-005 HS_POL/VS_POL, default 0/0, sync active level.
REQ-006 FIFO_DEPTH, default 16, power of two, >=4.
REQ-007 clk  in  1  pixel clock.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 enable  in  1  1 = timing runs; 0 = counters held at 0, outputs blank.
REQ-010 din_data  in  PW  pixel word, first channel in MSBs.
REQ-011 din_valid / din_sop  in  1 / 1  word valid / first pixel of frame.
REQ-012 din_ready  out  1  word accepted when din_valid & din_ready.
REQ-013 vid_data  out  PW  output pixel.
REQ-014 vid_datavalid / vid_h_sync / vid_v_sync  out  1 each  active region / syncs at HS_POL/VS_POL.
REQ-015 vid_underflow  out  1  one-cycle pulse per underflow event.
REQ-016 underflow_count  out  16  saturating event count; underflow_clr  in  1  clears it.
REQ-017 locked  out  1  high while in RUN.

Function
REQ-018 Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1) advance every clk while enable=1; h wraps to 0 and v increments at h=H_TOTAL-1; v wraps to 0 at v=V_TOTAL-1 with h wrap.
REQ-019 Active = h<H_ACTIVE & v<V_ACTIVE; hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync for the same V window, whole lines.
REQ-020 All vid_* outputs registered: counter state (h,v) appears on outputs exactly 1 clk later.
REQ-021 vid_datavalid follows Active regardless of lock state; vid_data = 0 whenever not RUN, not Active, or underflowing.
REQ-022 FIFO: FIFO_DEPTH words of {sop,data}, show-ahead head; din_ready = ~full & reset_n; push when full is impossible; push into empty FIFO visible at head next cycle, not same cycle.
REQ-023 States: IDLE, SEEK, WAIT_FRAME, RUN.
REQ-024 IDLE: entered on reset or enable=0; FIFO flushed on entry; leaves to SEEK when enable=1.
REQ-025 SEEK: pop head every cycle while head valid and head.sop=0; go WAIT_FRAME when head valid with sop=1 (not popped).
REQ-026 WAIT_FRAME: no pops; go RUN when h=H_TOTAL-1 & v=V_TOTAL-1 (next cycle is pixel 0,0).
REQ-027 RUN: on each Active cycle pop head and drive its data.
REQ-028 RUN, Active, FIFO empty: drive 0, pulse vid_underflow, increment count, go SEEK.
REQ-029 RUN, Active at (0,0), head.sop=0: treat as late frame: drive 0, no pop, go SEEK (not counted as underflow).
REQ-030 RUN, Active not at (0,0), head.sop=1: early frame: drive 0, no pop, go WAIT_FRAME (not counted).
REQ-031 Timing counters never pause for data loss; only lock state changes.
REQ-032 underflow_count saturates at 0xFFFF; underflow_clr with simultaneous event yields 0.
REQ-033 locked = (state==RUN), registered with the vid_* outputs.

Reset
REQ-034 reset_n=0 asynchronously forces: state IDLE, h=v=0, FIFO empty, din_ready=0, vid_data=0, vid_datavalid=0, syncs at inactive level, vid_underflow=0, underflow_count=0, locked=0.
REQ-035 Reset or enable drop mid-frame discards FIFO content; restart requires a new sop.

Verification (H 4/1/2/1, V 3/1/1/1, FIFO_DEPTH 4, BPS 8, CHANNELS 3)
REQ-036 Timing: enable=1, no input -> period 8 clk; hsync active h=5,6; vsync line 4; datavalid 4 clk per line on lines 0-2; 48-clk frame; locked=0, vid_data=0.
REQ-037 Lock: frame 12 words 0x000001..0x00000C, sop on first, fed ahead -> next frame outputs 0x000001..0x00000C in raster order on datavalid; locked=1.
REQ-038 Underflow: supply only 6 words of a frame -> 7th active pixel vid_data=0, vid_underflow 1-clk pulse, count=1, locked=0; relocks on next sop.
REQ-039 Junk skip: 3 words sop=0 then valid frame -> 3 words discarded, frame displays intact.
REQ-040 Early sop: sop on 5th word of frame -> pixel 5 = 0, WAIT_FRAME, new frame starts at next (0,0), count unchanged.
REQ-041 Reset mid-frame: reset_n low at h=2,v=1 -> all outputs at reset values same cycle; din_ready=0 until release.

Source files
------------

// File: rtl/video_stream_out_if.sv
`default_nettype none
// ============================================================================
// video_stream_out_if : pixel-in handshake and video-out bundle
// Rev 1.0
// ============================================================================
interface video_stream_out_if #(
  parameter int PW = 24
);
  logic [PW-1:0] din_data;
  logic          din_valid;
  logic          din_sop;
  logic          din_ready;
  logic [PW-1:0] vid_data;
  logic          vid_datavalid;
  logic          vid_h_sync;
  logic          vid_v_sync;
  logic          vid_underflow;

  modport master (
    output din_data, din_valid, din_sop,
    input  din_ready,
    input  vid_data, vid_datavalid, vid_h_sync, vid_v_sync, vid_underflow
  );

  modport slave (
    input  din_data, din_valid, din_sop,
    output din_ready,
    output vid_data, vid_datavalid, vid_h_sync, vid_v_sync, vid_underflow
  );
endinterface
`default_nettype wire

// File: rtl/video_stream_out.sv
`default_nettype none
// ============================================================================
// video_stream_out : raster timing generator fed by a small pixel FIFO
// Rev 1.0
// ============================================================================
module video_stream_out #(
  parameter int BPS        = 8,
  parameter int CHANNELS   = 3,
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        underflow_clr,
  output logic [15:0] underflow_count,
  output logic        locked,
  video_stream_out_if.slave bus
);
  localparam int PW      = BPS * CHANNELS;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SEEK       = 2'd1,
    S_WAIT_FRAME = 2'd2,
    S_RUN        = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic [PW:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic [PW-1:0] vid_data_q;
  logic          dv_q, hs_q, vs_q, uf_q, locked_q;
  logic [15:0]   ucnt_q;

  logic          fifo_empty, fifo_full, push, pop;
  logic          head_sop;
  logic [PW-1:0] head_data;
  logic          h_last, v_last, frame_end, at_origin, active;
  logic          hs_win, vs_win, uf_event, pix_valid;

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign {head_sop, head_data} = mem_q[rd_q[AW-1:0]];
  assign bus.din_ready = ~fifo_full & reset_n;
  assign push          = bus.din_valid & bus.din_ready;

  assign h_last    = (32'(h_q) == H_TOTAL - 1);
  assign v_last    = (32'(v_q) == V_TOTAL - 1);
  assign frame_end = h_last & v_last;
  assign at_origin = (h_q == '0) && (v_q == '0);
  assign active    = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
  assign hs_win    = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_win    = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    uf_event  = 1'b0;
    pix_valid = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_SEEK;
        S_SEEK: begin
          if (!fifo_empty) begin
            if (head_sop) state_d = S_WAIT_FRAME;
            else          pop     = 1'b1;
          end
        end
        S_WAIT_FRAME: if (frame_end) state_d = S_RUN;
        S_RUN: begin
          if (active) begin
            if (fifo_empty) begin
              uf_event = 1'b1;
              state_d  = S_SEEK;
            end else if (at_origin != head_sop) begin
              // sop missing at origin = late frame; sop mid-frame = early frame
              state_d = at_origin ? S_SEEK : S_WAIT_FRAME;
            end else begin
              pop       = 1'b1;
              pix_valid = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {bus.din_sop, bus.din_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      h_q        <= '0;
      v_q        <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      vid_data_q <= '0;
      dv_q       <= 1'b0;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      uf_q       <= 1'b0;
      ucnt_q     <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (!enable) begin
        h_q <= '0;
        v_q <= '0;
      end else if (h_last) begin
        h_q <= '0;
        v_q <= v_last ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end

      // Disabling drops any buffered words so a restart has to find a fresh sop.
      if (!enable) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
      end

      vid_data_q <= pix_valid ? head_data : '0;
      dv_q       <= enable & active;
      hs_q       <= (enable & hs_win) ? HS_POL : ~HS_POL;
      vs_q       <= (enable & vs_win) ? VS_POL : ~VS_POL;
      uf_q       <= uf_event;
      locked_q   <= (state_d == S_RUN);

      if (underflow_clr)                     ucnt_q <= '0;
      else if (uf_event && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign bus.vid_data      = vid_data_q;
  assign bus.vid_datavalid = dv_q;
  assign bus.vid_h_sync    = hs_q;
  assign bus.vid_v_sync    = vs_q;
  assign bus.vid_underflow = uf_q;
  assign underflow_count   = ucnt_q;
  assign locked            = locked_q;
endmodule
`default_nettype wire

// File: tb/tb_video_stream_out.sv
`default_nettype none
// ============================================================================
// tb_video_stream_out : table, directed and randomized checks of video_stream_out
// Rev 1.0
// ============================================================================
module tb_video_stream_out;
  localparam int PW = 24;
  localparam int HT = 8;
  localparam int VT = 6;
  localparam int FT = HT * VT;
  localparam int M_IDLE = 0, M_SEEK = 1, M_WAIT = 2, M_RUN = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        underflow_clr = 1'b0;
  logic [15:0] underflow_count;
  logic        locked;

  video_stream_out_if #(.PW(PW)) bus ();

  video_stream_out #(
    .BPS(8), .CHANNELS(3),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .underflow_clr(underflow_clr),
    .underflow_count(underflow_count),
    .locked(locked),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: raster position as a plain cycle index, FIFO as a queue
  int          t;
  int          mode;
  logic [24:0] q[$];
  logic [24:0] src[$];
  logic [23:0] e_data;
  logic        e_dv, e_hs, e_vs, e_uf, e_lk;
  logic [15:0] e_cnt;

  typedef struct {
    int   k;
    logic dv;
    logic hs;
    logic vs;
  } tvec_t;
  tvec_t tv[12];

  logic        cap_dv[49], cap_hs[49], cap_vs[49], cap_lk[49];
  logic [23:0] cap_data[49];
  logic [23:0] shown[$];
  logic [23:0] exp_list[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0;
    mode = M_IDLE;
    q.delete();
    e_data = '0; e_dv = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
    e_uf = 1'b0; e_lk = 1'b0; e_cnt = '0;
  endtask

  task automatic model_step(output bit acc);
    int h, v, nxt;
    bit act, ev, pop, origin;
    logic [23:0] d;
    acc = bus.din_valid && (q.size() < 4);
    if (!enable) begin
      q.delete();
      mode = M_IDLE;
      t = 0;
      e_data = '0; e_dv = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_uf = 1'b0; e_lk = 1'b0;
      if (underflow_clr) e_cnt = '0;
      return;
    end
    h = t % HT;
    v = t / HT;
    act = (h < 4) && (v < 3);
    origin = (h == 0) && (v == 0);
    ev = 1'b0; pop = 1'b0; d = '0; nxt = mode;
    case (mode)
      M_IDLE: nxt = M_SEEK;
      M_SEEK: if (q.size() > 0) begin
        if (q[0][24]) nxt = M_WAIT;
        else pop = 1'b1;
      end
      M_WAIT: if (h == HT - 1 && v == VT - 1) nxt = M_RUN;
      default: if (act) begin
        if (q.size() == 0) begin ev = 1'b1; nxt = M_SEEK; end
        else if (origin && !q[0][24]) nxt = M_SEEK;
        else if (!origin && q[0][24]) nxt = M_WAIT;
        else begin pop = 1'b1; d = q[0][23:0]; end
      end
    endcase
    if (pop) void'(q.pop_front());
    if (acc) q.push_back({bus.din_sop, bus.din_data});
    e_data = d;
    e_dv = act;
    e_hs = !(h == 5 || h == 6);
    e_vs = !(v == 4);
    e_uf = ev;
    if (underflow_clr) e_cnt = '0;
    else if (ev && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
    e_lk = (nxt == M_RUN);
    mode = nxt;
    t = (t + 1) % FT;
  endtask

  task automatic check_outputs();
    chk("vid_data", 32'(bus.vid_data), 32'(e_data));
    chk("vid_datavalid", 32'(bus.vid_datavalid), 32'(e_dv));
    chk("vid_h_sync", 32'(bus.vid_h_sync), 32'(e_hs));
    chk("vid_v_sync", 32'(bus.vid_v_sync), 32'(e_vs));
    chk("vid_underflow", 32'(bus.vid_underflow), 32'(e_uf));
    chk("underflow_count", 32'(underflow_count), 32'(e_cnt));
    chk("locked", 32'(locked), 32'(e_lk));
    chk("din_ready", 32'(bus.din_ready), 32'(q.size() < 4));
  endtask

  task automatic drive(input bit gate);
    bus.din_valid = (src.size() > 0) && gate;
    if (src.size() > 0) begin
      bus.din_sop  = src[0][24];
      bus.din_data = src[0][23:0];
    end else begin
      bus.din_sop  = 1'b0;
      bus.din_data = 24'($urandom);
    end
  endtask

  task automatic tick();
    bit acc;
    model_step(acc);
    @(posedge clk);
    @(negedge clk);
    if (acc) void'(src.pop_front());
    check_outputs();
  endtask

  task automatic push_frame(input int base, input int n, input int sop_idx);
    for (int i = 0; i < n; i++) src.push_back({(i == sop_idx), 24'(base + i)});
  endtask

  task automatic gen_frame();
    int r, base;
    r = int'($urandom % 10);
    base = int'($urandom & 32'h00FF_FF00);
    if (r < 6)       push_frame(base, 12, 0);
    else if (r < 8)  push_frame(base, 1 + int'($urandom % 14), 0);
    else if (r == 8) push_frame(base, 1 + int'($urandom % 3), -1);
    else             push_frame(base, 12, int'($urandom % 12));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_vid_data"}, 32'(bus.vid_data), 32'h0);
    chk({tag, "_datavalid"}, 32'(bus.vid_datavalid), 32'h0);
    chk({tag, "_h_sync"}, 32'(bus.vid_h_sync), 32'h1);
    chk({tag, "_v_sync"}, 32'(bus.vid_v_sync), 32'h1);
    chk({tag, "_underflow"}, 32'(bus.vid_underflow), 32'h0);
    chk({tag, "_count"}, 32'(underflow_count), 32'h0);
    chk({tag, "_locked"}, 32'(locked), 32'h0);
    chk({tag, "_din_ready"}, 32'(bus.din_ready), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit uf_seen, done, early_seen;
    logic [23:0] uf_data, early_data;
    logic uf_lk;
    logic [15:0] uf_cnt, early_cnt;

    tv[0]  = '{0,  1'b1, 1'b1, 1'b1};
    tv[1]  = '{3,  1'b1, 1'b1, 1'b1};
    tv[2]  = '{4,  1'b0, 1'b1, 1'b1};
    tv[3]  = '{5,  1'b0, 1'b0, 1'b1};
    tv[4]  = '{6,  1'b0, 1'b0, 1'b1};
    tv[5]  = '{7,  1'b0, 1'b1, 1'b1};
    tv[6]  = '{19, 1'b1, 1'b1, 1'b1};
    tv[7]  = '{24, 1'b0, 1'b1, 1'b1};
    tv[8]  = '{32, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{37, 1'b0, 1'b0, 1'b0};
    tv[10] = '{40, 1'b0, 1'b1, 1'b1};
    tv[11] = '{48, 1'b1, 1'b1, 1'b1};

    bus.din_valid = 1'b0;
    bus.din_sop   = 1'b0;
    bus.din_data  = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (2) begin drive(1'b1); tick(); end

    // free-running timing with no input
    enable = 1'b1;
    for (int j = 0; j < 49; j++) begin
      drive(1'b1);
      tick();
      cap_dv[j] = bus.vid_datavalid; cap_hs[j] = bus.vid_h_sync;
      cap_vs[j] = bus.vid_v_sync;    cap_lk[j] = locked;
      cap_data[j] = bus.vid_data;
    end
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tbl_dv_k%0d", tv[i].k), 32'(cap_dv[tv[i].k]), 32'(tv[i].dv));
      chk($sformatf("tbl_hs_k%0d", tv[i].k), 32'(cap_hs[tv[i].k]), 32'(tv[i].hs));
      chk($sformatf("tbl_vs_k%0d", tv[i].k), 32'(cap_vs[tv[i].k]), 32'(tv[i].vs));
      chk($sformatf("tbl_lk_k%0d", tv[i].k), 32'(cap_lk[tv[i].k]), 32'h0);
      chk($sformatf("tbl_data_k%0d", tv[i].k), 32'(cap_data[tv[i].k]), 32'h0);
    end

    // lock on a full frame, then a 6-word frame that underflows
    push_frame(1, 12, 0);
    push_frame(24'h101, 6, 0);
    shown.delete();
    uf_seen = 1'b0;
    for (int j = 0; j < 300 && !uf_seen; j++) begin
      drive(1'b1);
      tick();
      if (bus.vid_datavalid && locked) shown.push_back(bus.vid_data);
      if (bus.vid_underflow) begin
        uf_seen = 1'b1; uf_data = bus.vid_data; uf_lk = locked; uf_cnt = underflow_count;
      end
    end
    chk("uf_seen", 32'(uf_seen), 32'h1);
    chk("uf_data", 32'(uf_data), 32'h0);
    chk("uf_locked", 32'(uf_lk), 32'h0);
    chk("uf_count", 32'(uf_cnt), 32'h1);
    exp_list.delete();
    for (int i = 1; i <= 12; i++) exp_list.push_back(24'(i));
    for (int i = 0; i < 6; i++)   exp_list.push_back(24'(24'h101 + i));
    chk("lock_shown_len", 32'(shown.size()), 32'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < shown.size(); i++)
      chk($sformatf("lock_px%0d", i), 32'(shown[i]), 32'(exp_list[i]));
    drive(1'b1); tick();
    chk("uf_pulse_width", 32'(bus.vid_underflow), 32'h0);

    // junk words, a clean frame, a frame cut short by an early sop, then that frame
    for (int i = 0; i < 3; i++) src.push_back({1'b0, 24'(24'hAA0000 + i)});
    push_frame(24'h201, 12, 0);
    push_frame(24'h301, 4, 0);
    push_frame(24'h401, 12, 0);
    shown.delete();
    done = 1'b0; early_seen = 1'b0;
    for (int j = 0; j < 400 && !done; j++) begin
      drive(1'b1);
      tick();
      if (bus.vid_datavalid && locked) shown.push_back(bus.vid_data);
      if (bus.vid_datavalid && !locked && !early_seen && shown.size() == 16) begin
        early_seen = 1'b1; early_data = bus.vid_data; early_cnt = underflow_count;
      end
      done = (shown.size() >= 28);
    end
    chk("frames_done", 32'(done), 32'h1);
    chk("early_seen", 32'(early_seen), 32'h1);
    chk("early_px_data", 32'(early_data), 32'h0);
    chk("early_count", 32'(early_cnt), 32'h1);
    chk("count_after_frames", 32'(underflow_count), 32'h1);
    exp_list.delete();
    for (int i = 0; i < 12; i++) exp_list.push_back(24'(24'h201 + i));
    for (int i = 0; i < 4; i++)  exp_list.push_back(24'(24'h301 + i));
    for (int i = 0; i < 12; i++) exp_list.push_back(24'(24'h401 + i));
    chk("seq_shown_len", 32'(shown.size()), 32'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < shown.size(); i++)
      chk($sformatf("seq_px%0d", i), 32'(shown[i]), 32'(exp_list[i]));

    // asynchronous reset at h=2, v=1
    push_frame(24'h501, 12, 0);
    done = 1'b0;
    for (int j = 0; j < 200 && !done; j++) begin
      drive(1'b1);
      tick();
      done = (t == 10);
    end
    chk("reach_h2_v1", 32'(done), 32'h1);
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    @(negedge clk);
    chk("midrst_din_ready_hold", 32'(bus.din_ready), 32'h0);
    chk("midrst_locked_hold", 32'(locked), 32'h0);
    src.delete();
    model_reset();
    drive(1'b1);
    reset_n = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (src.size() == 0) gen_frame();
      underflow_clr = ($urandom % 50 == 0);
      if (enable && ($urandom % 400 == 0)) enable = 1'b0;
      else if (!enable && ($urandom % 4 == 0)) enable = 1'b1;
      drive($urandom % 8 != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
